// File: rtl/sync_arith_pkg.sv
// rtl/sync_arith_pkg.sv - opcode/state enums, status bit indices and flag packing helper
package sync_arith_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MUL  = 3'd5,
    OP_DIVU = 3'd6,
    OP_REMU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_e;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_V = 2;
  localparam int ST_C = 3;

  // Packs the four flags into their fixed status bit positions.
  function automatic logic [3:0] make_status(input logic c, input logic v,
                                             input logic n, input logic z);
    logic [3:0] st;
    st       = '0;
    st[ST_C] = c;
    st[ST_V] = v;
    st[ST_N] = n;
    st[ST_Z] = z;
    return st;
  endfunction

endpackage

// File: rtl/sync_arith_if.sv
// rtl/sync_arith_if.sv - operand/result handshake bundle between issue stage, unit and writeback
interface sync_arith_if
  import sync_arith_pkg::*;
#(
  parameter int BITS = 32
) ();

  logic [BITS-1:0] i_arg_A;
  logic [BITS-1:0] i_arg_B;
  op_e             i_op;
  logic            i_valid;
  logic            o_ready;
  logic [BITS-1:0] o_result;
  logic [3:0]      o_status;
  logic            o_valid;
  logic            i_ready;

  // Unit side.
  modport slave (
    input  i_arg_A, i_arg_B, i_op, i_valid, i_ready,
    output o_ready, o_result, o_status, o_valid
  );

  // Issue/writeback side.
  modport master (
    output i_arg_A, i_arg_B, i_op, i_valid, i_ready,
    input  o_ready, o_result, o_status, o_valid
  );

endinterface

// File: rtl/sync_arith_iter_core.sv
// rtl/sync_arith_iter_core.sv - shared BITS-step shift-add multiplier / restoring divider
module sync_arith_iter_core #(
  parameter int BITS = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_is_mul,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [BITS-1:0] o_lo,
  output logic [BITS-1:0] o_quo,
  output logic            o_hi_nz
);

  localparam int                CNT_W = $clog2(BITS);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BITS - 1);

  logic              r_busy;
  logic              r_mul;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*BITS-1:0] r_acc;   // product, or remainder in the low half
  logic [2*BITS-1:0] r_opnd;  // shifting multiplicand, or divisor in the low half
  logic [BITS-1:0]   r_sh;    // multiplier shifting right, or dividend becoming quotient

  logic [2*BITS-1:0] w_acc_nxt;
  logic [2*BITS-1:0] w_opnd_nxt;
  logic [BITS-1:0]   w_sh_nxt;
  logic [BITS:0]     w_rem_sh;
  logic [BITS:0]     w_rem_diff;

  // One step: add the current partial product, or shift in a dividend bit and try to subtract.
  always_comb begin
    w_acc_nxt  = r_acc;
    w_opnd_nxt = r_opnd;
    w_sh_nxt   = r_sh;
    w_rem_sh   = {r_acc[BITS-1:0], r_sh[BITS-1]};
    w_rem_diff = w_rem_sh - {1'b0, r_opnd[BITS-1:0]};
    if (r_mul) begin
      if (r_sh[0]) begin
        w_acc_nxt = r_acc + r_opnd;
      end
      w_opnd_nxt = r_opnd << 1;
      w_sh_nxt   = r_sh >> 1;
    end else if (!w_rem_diff[BITS]) begin
      w_acc_nxt = {{BITS{1'b0}}, w_rem_diff[BITS-1:0]};
      w_sh_nxt  = {r_sh[BITS-2:0], 1'b1};
    end else begin
      w_acc_nxt = {{BITS{1'b0}}, w_rem_sh[BITS-1:0]};
      w_sh_nxt  = {r_sh[BITS-2:0], 1'b0};
    end
  end

  // Load operands on start, then step once per edge until the last count.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_busy <= 1'b0;
      r_mul  <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_opnd <= '0;
      r_sh   <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_mul  <= i_is_mul;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_opnd <= {{BITS{1'b0}}, (i_is_mul ? i_a : i_b)};
      r_sh   <= i_is_mul ? i_b : i_a;
    end else if (r_busy) begin
      r_acc  <= w_acc_nxt;
      r_opnd <= w_opnd_nxt;
      r_sh   <= w_sh_nxt;
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Results are taken from the step being committed, so the top registers them on the final edge.
  assign o_busy  = r_busy;
  assign o_done  = r_busy && (r_cnt == LAST);
  assign o_lo    = w_acc_nxt[BITS-1:0];
  assign o_quo   = w_sh_nxt;
  assign o_hi_nz = |w_acc_nxt[2*BITS-1:BITS];

endmodule

// File: rtl/sync_arith_unit_seq.sv
// rtl/sync_arith_unit_seq.sv - handshaked arithmetic unit: FSM, single-cycle ALU, flags, output registers
module sync_arith_unit_seq
  import sync_arith_pkg::*;
#(
  parameter int BITS = 32
) (
  input logic         i_clk,
  input logic         i_reset,
  sync_arith_if.slave bus
);

  state_e          r_state;
  state_e          w_state_nxt;
  op_e             r_op;
  logic [BITS-1:0] r_result;
  logic [3:0]      r_status;
  logic            r_valid;

  logic            w_accept;
  logic            w_b_zero;
  logic            w_is_div;
  logic            w_iter_op;
  logic [BITS:0]   w_sum;
  logic [BITS:0]   w_diff;
  logic [BITS-1:0] w_alu_res;
  logic            w_alu_c;
  logic            w_alu_v;

  logic            w_core_busy;
  logic            w_core_done;
  logic            w_core_fin;
  logic [BITS-1:0] w_core_lo;
  logic [BITS-1:0] w_core_quo;
  logic            w_core_hi_nz;
  logic [BITS-1:0] w_iter_res;
  logic            w_iter_v;

  assign w_accept  = bus.i_valid && (r_state == IDLE);
  assign w_b_zero  = (bus.i_arg_B == '0);
  assign w_is_div  = (bus.i_op == OP_DIVU) || (bus.i_op == OP_REMU);
  assign w_iter_op = (bus.i_op == OP_MUL) || (w_is_div && !w_b_zero);

  sync_arith_iter_core #(
    .BITS (BITS)
  ) u_iter_core (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (w_accept && w_iter_op),
    .i_is_mul (bus.i_op == OP_MUL),
    .i_a      (bus.i_arg_A),
    .i_b      (bus.i_arg_B),
    .o_busy   (w_core_busy),
    .o_done   (w_core_done),
    .o_lo     (w_core_lo),
    .o_quo    (w_core_quo),
    .o_hi_nz  (w_core_hi_nz)
  );

  assign w_core_fin = w_core_busy && w_core_done;
  assign w_iter_res = (r_op == OP_DIVU) ? w_core_quo : w_core_lo;
  assign w_iter_v   = (r_op == OP_MUL) && w_core_hi_nz;

  // Single-cycle ops, plus the divide-by-zero shortcuts that never enter the iterative core.
  always_comb begin
    w_sum     = {1'b0, bus.i_arg_A} + {1'b0, bus.i_arg_B};
    w_diff    = {1'b0, bus.i_arg_A} - {1'b0, bus.i_arg_B};
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (bus.i_op)
      OP_ADD: begin
        w_alu_res = w_sum[BITS-1:0];
        w_alu_c   = w_sum[BITS];
        w_alu_v   = (bus.i_arg_A[BITS-1] == bus.i_arg_B[BITS-1]) &&
                    (w_sum[BITS-1] != bus.i_arg_A[BITS-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff[BITS-1:0];
        w_alu_c   = w_diff[BITS];
        w_alu_v   = (bus.i_arg_A[BITS-1] != bus.i_arg_B[BITS-1]) &&
                    (w_diff[BITS-1] != bus.i_arg_A[BITS-1]);
      end
      OP_AND:  w_alu_res = bus.i_arg_A & bus.i_arg_B;
      OP_OR:   w_alu_res = bus.i_arg_A | bus.i_arg_B;
      OP_XOR:  w_alu_res = bus.i_arg_A ^ bus.i_arg_B;
      OP_DIVU: begin
        w_alu_res = '1;
        w_alu_v   = 1'b1;
      end
      OP_REMU: begin
        w_alu_res = bus.i_arg_A;
        w_alu_v   = 1'b1;
      end
      default: w_alu_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: accept only in IDLE, leave DONE only when the consumer takes the result.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_state_nxt = w_iter_op ? ITER : DONE;
      ITER:    if (w_core_fin)  w_state_nxt = DONE;
      DONE:    if (bus.i_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result, flags and valid are written together; they hold while the consumer stalls.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_op     <= OP_ADD;
      r_result <= '0;
      r_status <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= bus.i_op;
      end
      if (w_accept && !w_iter_op) begin
        r_result <= w_alu_res;
        r_status <= make_status(w_alu_c, w_alu_v, w_alu_res[BITS-1], w_alu_res == '0);
        r_valid  <= 1'b1;
      end else if ((r_state == ITER) && w_core_fin) begin
        r_result <= w_iter_res;
        r_status <= make_status(1'b0, w_iter_v, w_iter_res[BITS-1], w_iter_res == '0);
        r_valid  <= 1'b1;
      end else if ((r_state == DONE) && bus.i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.o_ready  = (r_state == IDLE);
  assign bus.o_valid  = r_valid;
  assign bus.o_result = r_result;
  assign bus.o_status = r_status;

endmodule

// File: tb/tb_sync_arith_unit_seq.sv
// tb/tb_sync_arith_unit_seq.sv - directed bench with a behavioural model for sync_arith_unit_seq
module tb_sync_arith_unit_seq;
  import sync_arith_pkg::*;

  localparam int BIG = 32'h7fffffff;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  bit          exp_pending;
  int          exp_vcyc;
  int          exp_xcyc;
  logic [31:0] exp_res;
  logic [3:0]  exp_st;

  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  st;
    int          stall;
  } vec_t;

  vec_t vecs [14];

  sync_arith_if #(.BITS(32)) bus32 ();
  sync_arith_if #(.BITS(8))  bus8 ();

  sync_arith_unit_seq #(.BITS(32)) u_dut32 (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus32)
  );

  sync_arith_unit_seq #(.BITS(8)) u_dut8 (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outcome of one op from the arithmetic definitions; lat = edges after accept until o_valid.
  function automatic void model(input int w, input op_e op, input logic [63:0] a_in,
                                input logic [63:0] b_in, output logic [63:0] res,
                                output logic [3:0] st, output int lat);
    logic [127:0] full;
    logic [63:0]  mask, a, b;
    logic         c, v, sa, sb, sr;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    sa = a[w-1];
    sb = b[w-1];
    c = 1'b0; v = 1'b0; lat = 0; full = '0;
    case (op)
      OP_ADD: begin full = {64'd0, a} + {64'd0, b}; c = full[w]; end
      OP_SUB: begin full = {64'd0, a} - {64'd0, b}; c = (a < b); end
      OP_AND: full = {64'd0, a & b};
      OP_OR:  full = {64'd0, a | b};
      OP_XOR: full = {64'd0, a ^ b};
      OP_MUL: begin full = {64'd0, a} * {64'd0, b}; v = ((full >> w) != 0); lat = w; end
      OP_DIVU: if (b == 0) begin full = {64'd0, mask}; v = 1'b1; end
               else begin full = {64'd0, a / b}; lat = w; end
      default: if (b == 0) begin full = {64'd0, a}; v = 1'b1; end
               else begin full = {64'd0, a % b}; lat = w; end
    endcase
    res = full[63:0] & mask;
    sr  = res[w-1];
    if (op == OP_ADD) v = (sa == sb) && (sr != sa);
    if (op == OP_SUB) v = (sa != sb) && (sr != sa);
    st = {c, v, sr, (res == 0)};
  endfunction

  // One 32-bit op: pin the model to the hand value, arm the per-cycle compare, handle handshake.
  task automatic do_op32(input vec_t vv);
    logic [63:0] mres;
    logic [3:0]  mst;
    int          lat;
    int          n;
    model(32, vv.op, 64'(vv.a), 64'(vv.b), mres, mst, lat);
    chk("model32_result", mres, 64'(vv.res));
    chk("model32_status", 64'(mst), 64'(vv.st));
    bus32.i_op    = vv.op;
    bus32.i_arg_A = vv.a;
    bus32.i_arg_B = vv.b;
    bus32.i_valid = 1'b1;
    bus32.i_ready = 1'b0;
    exp_res     = mres[31:0];
    exp_st      = mst;
    exp_vcyc    = cyc + 1 + lat;
    exp_xcyc    = BIG;
    exp_pending = 1'b1;
    @(negedge clk);
    bus32.i_valid = (vv.stall > 0);
    bus32.i_op    = OP_MUL;
    bus32.i_arg_A = 32'd3;
    bus32.i_arg_B = 32'd3;
    n = 0;
    while (!bus32.o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("dut32_valid_seen", 64'(bus32.o_valid), 64'd1);
    repeat (vv.stall) @(negedge clk);
    bus32.i_ready = 1'b1;
    exp_xcyc = cyc + 1;
    @(negedge clk);
    bus32.i_ready = 1'b0;
    bus32.i_valid = 1'b0;
    exp_pending   = 1'b0;
  endtask

  task automatic do_op8(input op_e op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] hres, input logic [3:0] hst);
    logic [63:0] mres;
    logic [3:0]  mst;
    int          lat;
    int          start;
    int          n;
    model(8, op, 64'(a), 64'(b), mres, mst, lat);
    chk("model8_result", mres, 64'(hres));
    chk("model8_status", 64'(mst), 64'(hst));
    bus8.i_op    = op;
    bus8.i_arg_A = a;
    bus8.i_arg_B = b;
    bus8.i_valid = 1'b1;
    bus8.i_ready = 1'b0;
    start = cyc;
    @(negedge clk);
    bus8.i_valid = 1'b0;
    n = 0;
    while (!bus8.o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("dut8_latency", 64'(cyc - start - 1), 64'(lat));
    chk("dut8_result", 64'(bus8.o_result), mres);
    chk("dut8_status", 64'(bus8.o_status), 64'(mst));
    bus8.i_ready = 1'b1;
    @(negedge clk);
    bus8.i_ready = 1'b0;
    chk("dut8_valid_after_xfer", 64'(bus8.o_valid), 64'd0);
    chk("dut8_ready_after_xfer", 64'(bus8.o_ready), 64'd1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    exp_pending = 1'b0; exp_vcyc = BIG; exp_xcyc = BIG; exp_res = '0; exp_st = '0;
    rst_n = 1'b0;
    bus32.i_op = OP_ADD; bus32.i_arg_A = '0; bus32.i_arg_B = '0;
    bus32.i_valid = 1'b1; bus32.i_ready = 1'b0;
    bus8.i_op = OP_ADD; bus8.i_arg_A = '0; bus8.i_arg_B = '0;
    bus8.i_valid = 1'b0; bus8.i_ready = 1'b0;

    vecs = '{
      '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0110, 0},
      '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1001, 0},
      '{OP_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, 4'b1010, 0},
      '{OP_XOR,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 4'b0001, 0},
      '{OP_AND,  32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 4'b0000, 0},
      '{OP_OR,   32'h80000000, 32'h00000001, 32'h80000001, 4'b0010, 0},
      '{OP_MUL,  32'd1234,     32'd5678,     32'h006AE9BC, 4'b0000, 0},
      '{OP_MUL,  32'h00010000, 32'h00010000, 32'h00000000, 4'b0101, 0},
      '{OP_DIVU, 32'd100,      32'd7,        32'd14,       4'b0000, 0},
      '{OP_REMU, 32'd100,      32'd7,        32'd2,        4'b0000, 0},
      '{OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 4'b0010, 0},
      '{OP_DIVU, 32'd7,        32'd100,      32'd0,        4'b0001, 0},
      '{OP_DIVU, 32'd9,        32'd0,        32'hFFFFFFFF, 4'b0110, 5},
      '{OP_REMU, 32'd9,        32'd0,        32'd9,        4'b0100, 0}
    };

    fork
      // Per-cycle compare of the 32-bit unit against the armed expectation.
      begin
        forever begin
          @(posedge clk);
          cyc++;
          #2;
          if (rst_n) begin
            chk("o_valid", 64'(bus32.o_valid),
                64'(exp_pending && (cyc >= exp_vcyc) && (cyc < exp_xcyc)));
            chk("o_ready", 64'(bus32.o_ready), 64'(!exp_pending || (cyc >= exp_xcyc)));
            if (exp_pending && (cyc >= exp_vcyc) && (cyc < exp_xcyc)) begin
              chk("o_result", 64'(bus32.o_result), 64'(exp_res));
              chk("o_status", 64'(bus32.o_status), 64'(exp_st));
            end
          end
        end
      end
      // Directed sequence.
      begin
        repeat (2) @(negedge clk);
        chk("reset_valid", 64'(bus32.o_valid), 64'd0);
        chk("reset_result", 64'(bus32.o_result), 64'd0);
        chk("reset_status", 64'(bus32.o_status), 64'd0);
        chk("reset_ready", 64'(bus32.o_ready), 64'd1);
        chk("reset8_result", 64'(bus8.o_result), 64'd0);
        bus32.i_valid = 1'b0;
        rst_n = 1'b1;
        foreach (vecs[i]) do_op32(vecs[i]);

        // Abort a multiply after 10 steps with an asynchronous reset between edges.
        bus32.i_op = OP_MUL; bus32.i_arg_A = 32'd3; bus32.i_arg_B = 32'd5;
        bus32.i_valid = 1'b1;
        exp_res = 32'd15; exp_st = 4'b0000;
        exp_vcyc = cyc + 1 + 32; exp_xcyc = BIG; exp_pending = 1'b1;
        @(negedge clk);
        bus32.i_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_pending = 1'b0;
        bus32.i_valid = 1'b1;
        #1;
        chk("midrst_valid", 64'(bus32.o_valid), 64'd0);
        chk("midrst_result", 64'(bus32.o_result), 64'd0);
        chk("midrst_status", 64'(bus32.o_status), 64'd0);
        chk("midrst_ready", 64'(bus32.o_ready), 64'd1);
        repeat (2) @(negedge clk);
        bus32.i_valid = 1'b0;
        rst_n = 1'b1;
        do_op32('{OP_DIVU, 32'd100, 32'd7, 32'd14, 4'b0000, 0});

        do_op8(OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0110);
        do_op8(OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1001);
        do_op8(OP_MUL, 8'd15, 8'd17, 8'hFF, 4'b0010);
        do_op8(OP_MUL, 8'd16, 8'd16, 8'h00, 4'b0101);
        repeat (2) @(negedge clk);
      end
      // Watchdog.
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_arith_unit_seq.md
Name: sync_arith_unit_seq

Overview:
Parametrised successor to the 2-bit-opcode synchronous arithmetic unit. Adds a 3-bit opcode and iterative multi-cycle MUL/DIVU/REMU. Adds valid/ready handshakes on input and output, so it can sit between a register-read stage and a writeback stage that may stall. Single-cycle ops complete in 1 clock; iterative ops take BITS clocks.

Parameters:
BITS, 32, operand/result width (legal 4..64).

Ports:
i_clk  in  1  rising-edge clock
i_reset  in  1  asynchronous, active-low reset (0 = reset)
i_arg_A  in  BITS  operand A, unsigned unless noted
i_arg_B  in  BITS  operand B
i_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 DIVU, 7 REMU
i_valid  in  1  operands/op valid
o_ready  out  1  unit can accept (high only in IDLE)
o_result  out  BITS  registered result
o_status  out  4  registered flags {C,V,N,Z} = bits [3:0] as {3:C, 2:V, 1:N, 0:Z}
o_valid  out  1  o_result/o_status valid
i_ready  in  1  consumer accepts result

Behaviour:
- Reset (i_reset=0, async): state=IDLE; o_result=0, o_status=0, o_valid=0, iteration counter=0. o_ready decodes from state, so it reads 1. i_valid is ignored while reset is asserted. Reset mid-iteration aborts the operation; no result is produced.
- FSM states: IDLE, ITER, DONE.
- Transitions:
  - IDLE --(i_valid & o_ready)--> DONE for ops 0-4, and for DIVU/REMU with B==0.
  - IDLE --(i_valid & o_ready)--> ITER for MUL, and for DIVU/REMU with B!=0. Operands and op are captured on the accept edge.
  - ITER --(counter==BITS-1)--> DONE. Otherwise counter++ each edge.
  - DONE --(i_ready)--> IDLE. Otherwise hold.
- Latency:
  - o_valid rises on the edge after the accept edge for single-cycle ops.
  - o_valid rises BITS edges after the accept edge for iterative ops (one partial product or remainder step per edge).
- Handshake:
  - o_ready=0 in ITER and DONE; i_valid there is ignored, not queued.
  - o_result/o_status are stable while o_valid=1 and i_ready=0.
  - Transfer happens on an edge with o_valid & i_ready; o_valid falls on that edge.
  - No accept on the same edge as a transfer. Peak throughput is one op per 2 cycles.
- Arithmetic (all results truncated to BITS):
  - ADD: C = carry out; V = signed overflow.
  - SUB (A-B): C = borrow (A<B unsigned); V = signed overflow.
  - AND/OR/XOR: C=0, V=0.
  - MUL: unsigned, result = low BITS of 2*BITS product; V = high half !=0; C=0. Shift-add, LSB of B first.
  - DIVU/REMU: unsigned restoring division, one quotient bit per cycle, MSB first. DIVU returns the quotient, REMU the remainder. C=0, V=0.
  - Divide by zero (B==0): 1-cycle completion. DIVU gives all-ones; REMU gives A. V=1, C=0.
- Flags for all ops: Z = (o_result==0); N = o_result[BITS-1]. Flags are written in the same edge as o_result.

Decomposition:
- Package sync_arith_pkg holds:
  - op_e enum (3 bits, values above);
  - state_e enum {IDLE, ITER, DONE};
  - status bit index localparams ST_Z=0, ST_N=1, ST_V=2, ST_C=3.
- One sub-module, sync_arith_iter_core:
  - contains the shared BITS-cycle shift-add multiplier / restoring divider datapath;
  - counter, accumulator and remainder registers;
  - start/busy/done signals;
  - same async active-low reset.
- Top level holds the FSM, single-cycle ALU, flag logic and output registers.

Test Plan:
- ADD A=0x7FFFFFFF B=1 -> o_result=0x80000000, o_status=4'b0110, o_valid 1 edge after accept. Then ADD 0xFFFFFFFF+1 -> 0x00000000, o_status=4'b1001.
- SUB A=5 B=7 -> 0xFFFFFFFE, o_status=4'b1010. XOR 0xA5A5A5A5^0xA5A5A5A5 -> 0, o_status=4'b0001.
- MUL 1234*5678 -> 0x006AE9BC, o_status=0000, o_valid exactly 32 edges after accept. MUL 0x10000*0x10000 -> 0, o_status=4'b0101.
- DIVU 100/7 -> 14, REMU 100/7 -> 2 (32-edge latency each). DIVU 9/0 -> 0xFFFFFFFF, o_status=4'b0110, 1-edge latency. REMU 9/0 -> 9, o_status=4'b0100.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid while driving i_valid=1 with new ops -> outputs unchanged, o_ready=0, no op captured. Raise i_ready -> transfer, IDLE next edge, next op accepted and correct.
- Reset mid-MUL (after 10 iterations), asynchronously between edges -> o_valid/o_result/o_status drop to 0 immediately, o_ready=1. After release, DIVU 100/7 completes with 14. Repeat the ADD/MUL checks at BITS=8 (MUL 15*17 -> 0xFF, status 4'b0010; 16*16 -> 0, status 4'b0101).
